// File: rtl/wam_game_if.sv
// Whack-a-mole game core bus: switch/pulse inputs toward the core, status and display values back.
interface wam_game_if #(
    parameter int unsigned POS_W   = 4,
    parameter int unsigned SCORE_W = 7,
    parameter int unsigned TIME_W  = 7
);
    logic               play;
    logic [1:0]         mode;
    logic [SCORE_W-1:0] max_hits;
    logic               light_on;
    logic               light_off;
    logic [POS_W-1:0]   light_pos;
    logic               key_valid;
    logic [POS_W-1:0]   key_pos;
    logic [2:0]         state;
    logic               countdown_en;
    logic               flick_en;
    logic               clear_n;
    logic [2:0]         ready_count;
    logic [TIME_W-1:0]  time_left;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] flicks;
    logic [1:0]         lives_left;
    logic               game_over;

    modport master (
        output play, mode, max_hits, light_on, light_off, light_pos, key_valid, key_pos,
        input  state, countdown_en, flick_en, clear_n, ready_count, time_left,
               score, flicks, lives_left, game_over
    );

    modport slave (
        input  play, mode, max_hits, light_on, light_off, light_pos, key_valid, key_pos,
        output state, countdown_en, flick_en, clear_n, ready_count, time_left,
               score, flicks, lives_left, game_over
    );
endinterface

// File: rtl/wam_game_core.sv
// Whack-a-mole game sequencer: game FSM, ready countdown, game timer, lives and hit scoring.
module wam_game_core #(
    parameter int unsigned POS_W      = 4,
    parameter int unsigned SCORE_W    = 7,
    parameter int unsigned TIME_W     = 7,
    parameter int unsigned TICK_MAX   = 49_999_999,
    parameter int unsigned READY_SECS = 5,
    parameter int unsigned GAME_SECS  = 60,
    parameter int unsigned LIVES      = 3
) (
    input  logic        clk,
    input  logic        reset,
    wam_game_if.slave   bus
);
    localparam int unsigned PRESC_W = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RESTART = 3'd1;
    localparam logic [2:0] S_READY   = 3'd2;
    localparam logic [2:0] S_PLAY    = 3'd3;
    localparam logic [2:0] S_OVER    = 3'd4;

    localparam logic [1:0] M_TIMED = 2'd1;
    localparam logic [1:0] M_LIVES = 2'd2;

    logic [2:0]         state_q;
    logic [2:0]         state_nx;
    logic [PRESC_W-1:0] presc;
    logic [1:0]         mode_q;
    logic [SCORE_W-1:0] max_q;
    logic [2:0]         ready_count;
    logic [TIME_W-1:0]  time_left;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] flicks;
    logic [1:0]         lives_left;
    logic               lit;
    logic [POS_W-1:0]   cur_pos;
    logic               countdown_en;
    logic               flick_en;
    logic               clear_n;
    logic               game_over;

    logic in_run;
    logic in_play;
    logic tick;
    logic hit;
    logic miss;
    logic end_cond;

    // Run/tick qualification and hit/miss classification of the current pulses
    always_comb begin
        in_run  = (state_q == S_READY) || (state_q == S_PLAY);
        in_play = (state_q == S_PLAY);
        tick    = in_run && (presc == PRESC_W'(TICK_MAX));
        hit     = in_play && bus.key_valid && lit && (bus.key_pos == cur_pos);
        miss    = in_play && ((bus.key_valid && !hit) || (bus.light_off && lit && !hit));
        case (mode_q)
            M_TIMED: end_cond = (time_left == '0);
            M_LIVES: end_cond = (lives_left == 2'd0);
            default: end_cond = (flicks == max_q) && !lit;
        endcase
    end

    // Game FSM next-state; play overrides everything once a game has been requested
    always_comb begin
        state_nx = state_q;
        case (state_q)
            S_IDLE:    if (bus.play) state_nx = S_RESTART;
            S_RESTART: state_nx = S_READY;
            S_READY: begin
                if (bus.play)                             state_nx = S_RESTART;
                else if (tick && (ready_count == 3'd1))   state_nx = S_PLAY;
            end
            S_PLAY: begin
                if (bus.play)      state_nx = S_RESTART;
                else if (end_cond) state_nx = S_OVER;
            end
            S_OVER:    if (bus.play) state_nx = S_RESTART;
            default:   state_nx = S_IDLE;
        endcase
    end

    // Game FSM state register
    always_ff @(posedge clk) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_nx;
    end

    // Status outputs registered alongside the state so they align with it
    always_ff @(posedge clk) begin
        if (!reset) begin
            countdown_en <= 1'b0;
            flick_en     <= 1'b0;
            clear_n      <= 1'b1;
            game_over    <= 1'b0;
        end else begin
            countdown_en <= (state_nx == S_READY);
            flick_en     <= (state_nx == S_PLAY);
            clear_n      <= (state_nx != S_RESTART);
            game_over    <= (state_nx == S_OVER);
        end
    end

    // Prescaler, countdowns, scoring and lives; restart snapshots switches and clears the game
    always_ff @(posedge clk) begin
        if (!reset) begin
            presc       <= '0;
            mode_q      <= 2'd0;
            max_q       <= '0;
            ready_count <= 3'd0;
            time_left   <= '0;
            score       <= '0;
            flicks      <= '0;
            lives_left  <= 2'd0;
            lit         <= 1'b0;
            cur_pos     <= '0;
        end else if (state_nx == S_RESTART) begin
            presc       <= '0;
            mode_q      <= bus.mode;
            max_q       <= bus.max_hits;
            ready_count <= 3'(READY_SECS);
            time_left   <= TIME_W'(GAME_SECS);
            score       <= '0;
            flicks      <= '0;
            lives_left  <= 2'(LIVES);
            lit         <= 1'b0;
            cur_pos     <= '0;
        end else begin
            if (in_run) presc <= tick ? '0 : presc + PRESC_W'(1);
            if ((state_q == S_READY) && tick && (ready_count != 3'd0))
                ready_count <= ready_count - 3'd1;
            if (in_play) begin
                if (tick && (mode_q == M_TIMED) && (time_left != '0))
                    time_left <= time_left - TIME_W'(1);
                if (hit && (score != '1))
                    score <= score + SCORE_W'(1);
                if (bus.light_on && (flicks != '1))
                    flicks <= flicks + SCORE_W'(1);
                // Old light resolves first; a simultaneous new light wins
                if (bus.light_on) begin
                    lit     <= 1'b1;
                    cur_pos <= bus.light_pos;
                end else if (bus.light_off || hit) begin
                    lit <= 1'b0;
                end
                if (miss && (mode_q == M_LIVES) && (lives_left != 2'd0))
                    lives_left <= lives_left - 2'd1;
            end
        end
    end

    // Drive the bus from internal registers
    always_comb begin
        bus.state        = state_q;
        bus.countdown_en = countdown_en;
        bus.flick_en     = flick_en;
        bus.clear_n      = clear_n;
        bus.ready_count  = ready_count;
        bus.time_left    = time_left;
        bus.score        = score;
        bus.flicks       = flicks;
        bus.lives_left   = lives_left;
        bus.game_over    = game_over;
    end
endmodule

// File: tb/tb_wam_game_core.sv
// Directed bench for wam_game_core with a short tick period.
module tb_wam_game_core;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    wam_game_if #(.POS_W(4), .SCORE_W(7), .TIME_W(7)) bus ();

    wam_game_core #(
        .POS_W(4), .SCORE_W(7), .TIME_W(7),
        .TICK_MAX(3), .READY_SECS(2), .GAME_SECS(3), .LIVES(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pulse play for one cycle, then wait out RESTART
    task automatic restart_game(input logic [1:0] m, input logic [6:0] mx);
        bus.mode     = m;
        bus.max_hits = mx;
        bus.play     = 1'b1;
        step();
        bus.play     = 1'b0;
        step();
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b0;
        bus.play      = 1'b0;
        bus.mode      = 2'd0;
        bus.max_hits  = 7'd2;
        bus.light_on  = 1'b0;
        bus.light_off = 1'b0;
        bus.light_pos = 4'd0;
        bus.key_valid = 1'b0;
        bus.key_pos   = 4'd0;

        // Reset
        step(); step();
        chk("rst_state", 32'(bus.state), 0);
        chk("rst_score", 32'(bus.score), 0);
        chk("rst_clear_n", 32'(bus.clear_n), 1);
        chk("rst_game_over", 32'(bus.game_over), 0);
        chk("rst_ready", 32'(bus.ready_count), 0);
        reset = 1'b1;
        step();
        chk("idle_hold", 32'(bus.state), 0);

        // Normal game, max_hits=2: restart and ready countdown
        bus.play = 1'b1;
        step();
        chk("restart_state", 32'(bus.state), 1);
        chk("restart_clear_n", 32'(bus.clear_n), 0);
        bus.play = 1'b0;
        step();
        chk("ready_state", 32'(bus.state), 2);
        chk("ready_cnt2", 32'(bus.ready_count), 2);
        chk("ready_cden", 32'(bus.countdown_en), 1);
        chk("ready_clear_n", 32'(bus.clear_n), 1);
        repeat (3) step();
        chk("ready_cnt2_hold", 32'(bus.ready_count), 2);
        step();
        chk("ready_cnt1", 32'(bus.ready_count), 1);
        repeat (3) step();
        chk("ready_still", 32'(bus.state), 2);
        step();
        chk("play_state", 32'(bus.state), 3);
        chk("play_ready0", 32'(bus.ready_count), 0);
        chk("play_flick_en", 32'(bus.flick_en), 1);
        chk("play_cden", 32'(bus.countdown_en), 0);

        bus.light_on = 1'b1; bus.light_pos = 4'd5;
        step();
        bus.light_on = 1'b0;
        chk("n_flicks1", 32'(bus.flicks), 1);
        bus.key_valid = 1'b1; bus.key_pos = 4'd5;
        step();
        bus.key_valid = 1'b0;
        chk("n_hit_score", 32'(bus.score), 1);
        bus.light_on = 1'b1; bus.light_pos = 4'd3;
        step();
        bus.light_on = 1'b0;
        chk("n_flicks2", 32'(bus.flicks), 2);
        chk("n_lit_play", 32'(bus.state), 3);
        bus.light_off = 1'b1;
        step();
        bus.light_off = 1'b0;
        chk("n_expire_score", 32'(bus.score), 1);
        chk("n_expire_state", 32'(bus.state), 3);
        step();
        chk("n_over_state", 32'(bus.state), 4);
        chk("n_over_flag", 32'(bus.game_over), 1);
        chk("n_over_score", 32'(bus.score), 1);

        // Pulses ignored outside PLAY
        bus.light_on = 1'b1; bus.light_pos = 4'd5;
        bus.key_valid = 1'b1; bus.key_pos = 4'd5;
        step(); step();
        bus.light_on = 1'b0; bus.key_valid = 1'b0;
        chk("over_ign_score", 32'(bus.score), 1);
        chk("over_ign_flicks", 32'(bus.flicks), 2);

        // Timed game
        bus.mode = 2'd1;
        bus.play = 1'b1;
        step();
        chk("t_restart_score", 32'(bus.score), 0);
        chk("t_restart_flicks", 32'(bus.flicks), 0);
        bus.play = 1'b0;
        step();
        repeat (8) step();
        chk("t_play", 32'(bus.state), 3);
        chk("t_time3", 32'(bus.time_left), 3);
        repeat (4) step();
        chk("t_time2", 32'(bus.time_left), 2);
        repeat (4) step();
        chk("t_time1", 32'(bus.time_left), 1);
        repeat (4) step();
        chk("t_time0", 32'(bus.time_left), 0);
        chk("t_still_play", 32'(bus.state), 3);
        step();
        chk("t_over", 32'(bus.state), 4);
        chk("t_score0", 32'(bus.score), 0);
        chk("t_time_hold", 32'(bus.time_left), 0);

        // Lives game
        bus.mode = 2'd2;
        bus.play = 1'b1;
        step();
        chk("l_restart_lives", 32'(bus.lives_left), 2);
        bus.play = 1'b0;
        step();
        repeat (8) step();
        chk("l_play", 32'(bus.state), 3);
        bus.light_on = 1'b1; bus.light_pos = 4'd6;
        step();
        bus.light_on = 1'b0;
        bus.key_valid = 1'b1; bus.key_pos = 4'd6; bus.light_off = 1'b1;
        step();
        bus.key_valid = 1'b0; bus.light_off = 1'b0;
        chk("l_hit_off_score", 32'(bus.score), 1);
        chk("l_hit_off_lives", 32'(bus.lives_left), 2);
        bus.light_on = 1'b1; bus.light_pos = 4'd4;
        step();
        bus.light_on = 1'b0;
        bus.key_valid = 1'b1; bus.key_pos = 4'd7;
        step();
        bus.key_valid = 1'b0;
        chk("l_wrong_lives", 32'(bus.lives_left), 1);
        chk("l_wrong_score", 32'(bus.score), 1);
        chk("l_wrong_state", 32'(bus.state), 3);
        bus.light_off = 1'b1;
        step();
        bus.light_off = 1'b0;
        chk("l_expire_lives", 32'(bus.lives_left), 0);
        chk("l_expire_state", 32'(bus.state), 3);
        step();
        chk("l_over", 32'(bus.state), 4);
        chk("l_over_lives", 32'(bus.lives_left), 0);

        // Normal mode with max_hits=0 ends right after the first PLAY cycle
        restart_game(2'd0, 7'd0);
        repeat (8) step();
        chk("z_play", 32'(bus.state), 3);
        step();
        chk("z_over", 32'(bus.state), 4);

        // Mid-PLAY restart, then reset during READY
        restart_game(2'd0, 7'd5);
        repeat (8) step();
        chk("m_play", 32'(bus.state), 3);
        bus.light_on = 1'b1; bus.light_pos = 4'd1;
        step();
        bus.light_on = 1'b0;
        bus.key_valid = 1'b1; bus.key_pos = 4'd1;
        step();
        bus.key_valid = 1'b0;
        chk("m_score1", 32'(bus.score), 1);
        chk("m_flicks1", 32'(bus.flicks), 1);
        bus.play = 1'b1;
        step();
        chk("m_restart", 32'(bus.state), 1);
        chk("m_score0", 32'(bus.score), 0);
        chk("m_flicks0", 32'(bus.flicks), 0);
        chk("m_clear_n", 32'(bus.clear_n), 0);
        bus.play = 1'b0;
        step();
        chk("m_ready", 32'(bus.state), 2);
        step(); step();
        reset = 1'b0;
        step();
        chk("m_rst_state", 32'(bus.state), 0);
        chk("m_rst_cden", 32'(bus.countdown_en), 0);
        chk("m_rst_ready", 32'(bus.ready_count), 0);
        chk("m_rst_clear_n", 32'(bus.clear_n), 1);
        reset = 1'b1;
        step();
        chk("m_idle", 32'(bus.state), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
